// File: rtl/core_types_pkg.sv
// Shared rename/ROB types for the dispatch unit, plus the recovery sequencer state
// and modulo ROB index helpers.
package core_types_pkg;

  localparam int unsigned ROB_ENTRIES        = 16;
  localparam int unsigned NUM_ARCH_REGS      = 32;
  localparam int unsigned NUM_PHYS_REGS      = 64;
  localparam int unsigned CHECKPOINT_COLUMNS = 4;

  localparam int unsigned ROB_IDX_W  = $clog2(ROB_ENTRIES);
  localparam int unsigned ARCH_W     = $clog2(NUM_ARCH_REGS);
  localparam int unsigned PHYS_W     = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CKC_W      = $clog2(CHECKPOINT_COLUMNS);
  localparam int unsigned WALK_CNT_W = $clog2(ROB_ENTRIES + 1);

  typedef logic [ROB_IDX_W-1:0] ROB_index_t;
  typedef logic [ARCH_W-1:0]    arch_reg_tag_t;
  typedef logic [PHYS_W-1:0]    phys_reg_tag_t;
  typedef logic [CKC_W-1:0]     checkpoint_column_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    WALK    = 2'd2,
    DONE    = 2'd3
  } recovery_state_t;

  // Modulo ROB_ENTRIES increment/decrement; correct for non-power-of-two depths too.
  function automatic ROB_index_t rob_inc(input ROB_index_t i);
    return (32'(i) == ROB_ENTRIES - 1) ? '0 : ROB_index_t'(32'(i) + 32'd1);
  endfunction

  function automatic ROB_index_t rob_dec(input ROB_index_t i);
    return (i == '0) ? ROB_index_t'(ROB_ENTRIES - 1) : i - ROB_index_t'(1);
  endfunction

endpackage

// File: rtl/map_table_recovery_controller.sv
// Map table recovery sequencer: one-cycle checkpoint restore, falling back to a
// backward ROB walk that reverts younger renames; also forwards checkpoint invalidates.
module map_table_recovery_controller
  import core_types_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  output logic               DUT_error,

  input  logic               recover_req_valid,
  output logic               recover_req_ready,
  input  ROB_index_t         recover_req_ROB_index,
  input  checkpoint_column_t recover_req_column,

  input  logic               invalidate_req_valid,
  output logic               invalidate_req_ready,
  input  ROB_index_t         invalidate_req_ROB_index,
  input  checkpoint_column_t invalidate_req_column,

  input  ROB_index_t         rob_tail_index,

  output ROB_index_t         rob_read_index,
  input  logic               rob_read_dest_valid,
  input  arch_reg_tag_t      rob_read_arch_tag,
  input  phys_reg_tag_t      rob_read_safe_phys_tag,
  input  phys_reg_tag_t      rob_read_spec_phys_tag,

  output logic               revert_valid,
  output arch_reg_tag_t      revert_dest_arch_reg_tag,
  output phys_reg_tag_t      revert_safe_dest_phys_reg_tag,
  output phys_reg_tag_t      revert_speculated_dest_phys_reg_tag,

  output logic               restore_checkpoint_valid,
  output logic               restore_checkpoint_speculate_failed,
  output ROB_index_t         restore_checkpoint_ROB_index,
  output checkpoint_column_t restore_checkpoint_safe_column,
  input  logic               restore_checkpoint_success,

  output logic               dispatch_stall,
  output logic               recover_done
);

  recovery_state_t           state_q, state_d;
  ROB_index_t                br_idx_q, br_idx_d;
  checkpoint_column_t        col_q, col_d;
  ROB_index_t                walk_idx_q, walk_idx_d;
  logic [WALK_CNT_W-1:0]     walk_cnt_q, walk_cnt_d;
  logic                      error_q, error_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      br_idx_q   <= '0;
      col_q      <= '0;
      walk_idx_q <= '0;
      walk_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      br_idx_q   <= br_idx_d;
      col_q      <= col_d;
      walk_idx_q <= walk_idx_d;
      walk_cnt_q <= walk_cnt_d;
      error_q    <= error_d;
    end
  end

  // Next-state and output decode; readies depend only on state and recover_req_valid.
  always_comb begin
    state_d    = state_q;
    br_idx_d   = br_idx_q;
    col_d      = col_q;
    walk_idx_d = walk_idx_q;
    walk_cnt_d = walk_cnt_q;
    error_d    = error_q;

    recover_req_ready                   = 1'b0;
    invalidate_req_ready                = 1'b0;
    rob_read_index                      = '0;
    revert_valid                        = 1'b0;
    revert_dest_arch_reg_tag            = '0;
    revert_safe_dest_phys_reg_tag       = '0;
    revert_speculated_dest_phys_reg_tag = '0;
    restore_checkpoint_valid            = 1'b0;
    restore_checkpoint_speculate_failed = 1'b0;
    restore_checkpoint_ROB_index        = '0;
    restore_checkpoint_safe_column      = '0;
    dispatch_stall                      = 1'b1;
    recover_done                        = 1'b0;

    unique case (state_q)
      IDLE: begin
        dispatch_stall       = 1'b0;
        recover_req_ready    = 1'b1;
        invalidate_req_ready = !recover_req_valid;
        if (recover_req_valid) begin
          br_idx_d   = recover_req_ROB_index;
          col_d      = recover_req_column;
          walk_idx_d = rob_dec(rob_tail_index);
          walk_cnt_d = '0;
          if (recover_req_ROB_index == rob_tail_index) error_d = 1'b1;
          state_d    = RESTORE;
        end else if (invalidate_req_valid) begin
          // Invalidate failures are benign; the response is ignored.
          restore_checkpoint_valid       = 1'b1;
          restore_checkpoint_ROB_index   = invalidate_req_ROB_index;
          restore_checkpoint_safe_column = invalidate_req_column;
        end
      end

      RESTORE: begin
        restore_checkpoint_valid            = 1'b1;
        restore_checkpoint_speculate_failed = 1'b1;
        restore_checkpoint_ROB_index        = br_idx_q;
        restore_checkpoint_safe_column      = col_q;
        if (restore_checkpoint_success || (walk_idx_q == br_idx_q)) state_d = DONE;
        else                                                        state_d = WALK;
      end

      WALK: begin
        rob_read_index                      = walk_idx_q;
        revert_valid                        = rob_read_dest_valid;
        revert_dest_arch_reg_tag            = rob_read_arch_tag;
        revert_safe_dest_phys_reg_tag       = rob_read_safe_phys_tag;
        revert_speculated_dest_phys_reg_tag = rob_read_spec_phys_tag;
        walk_idx_d = rob_dec(walk_idx_q);
        walk_cnt_d = walk_cnt_q + WALK_CNT_W'(1);
        // A walk longer than the ROB can hold means the tail/branch indices were bogus.
        if (walk_cnt_q >= WALK_CNT_W'(ROB_ENTRIES - 1)) begin
          error_d = 1'b1;
          state_d = DONE;
        end else if (walk_idx_q == rob_inc(br_idx_q)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        recover_done = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign DUT_error = error_q;

endmodule

// File: tb/tb_map_table_recovery_controller.sv
// Directed bench for map_table_recovery_controller: a scoreboard queue of expected
// restore/read/revert/done events checked against DUT activity every cycle.
module tb_map_table_recovery_controller;
  import core_types_pkg::*;

  localparam logic [3:0] EV_RST  = 4'd1;
  localparam logic [3:0] EV_READ = 4'd2;
  localparam logic [3:0] EV_REV  = 4'd3;
  localparam logic [3:0] EV_DONE = 4'd4;

  logic               CLK, nRST, DUT_error;
  logic               recover_req_valid, recover_req_ready;
  ROB_index_t         recover_req_ROB_index;
  checkpoint_column_t recover_req_column;
  logic               invalidate_req_valid, invalidate_req_ready;
  ROB_index_t         invalidate_req_ROB_index;
  checkpoint_column_t invalidate_req_column;
  ROB_index_t         rob_tail_index, rob_read_index;
  logic               rob_read_dest_valid;
  arch_reg_tag_t      rob_read_arch_tag;
  phys_reg_tag_t      rob_read_safe_phys_tag, rob_read_spec_phys_tag;
  logic               revert_valid;
  arch_reg_tag_t      revert_dest_arch_reg_tag;
  phys_reg_tag_t      revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag;
  logic               restore_checkpoint_valid, restore_checkpoint_speculate_failed;
  ROB_index_t         restore_checkpoint_ROB_index;
  checkpoint_column_t restore_checkpoint_safe_column;
  logic               restore_checkpoint_success;
  logic               dispatch_stall, recover_done;

  map_table_recovery_controller dut (
    .CLK                                 (CLK),
    .nRST                                (nRST),
    .DUT_error                           (DUT_error),
    .recover_req_valid                   (recover_req_valid),
    .recover_req_ready                   (recover_req_ready),
    .recover_req_ROB_index               (recover_req_ROB_index),
    .recover_req_column                  (recover_req_column),
    .invalidate_req_valid                (invalidate_req_valid),
    .invalidate_req_ready                (invalidate_req_ready),
    .invalidate_req_ROB_index            (invalidate_req_ROB_index),
    .invalidate_req_column               (invalidate_req_column),
    .rob_tail_index                      (rob_tail_index),
    .rob_read_index                      (rob_read_index),
    .rob_read_dest_valid                 (rob_read_dest_valid),
    .rob_read_arch_tag                   (rob_read_arch_tag),
    .rob_read_safe_phys_tag              (rob_read_safe_phys_tag),
    .rob_read_spec_phys_tag              (rob_read_spec_phys_tag),
    .revert_valid                        (revert_valid),
    .revert_dest_arch_reg_tag            (revert_dest_arch_reg_tag),
    .revert_safe_dest_phys_reg_tag       (revert_safe_dest_phys_reg_tag),
    .revert_speculated_dest_phys_reg_tag (revert_speculated_dest_phys_reg_tag),
    .restore_checkpoint_valid            (restore_checkpoint_valid),
    .restore_checkpoint_speculate_failed (restore_checkpoint_speculate_failed),
    .restore_checkpoint_ROB_index        (restore_checkpoint_ROB_index),
    .restore_checkpoint_safe_column      (restore_checkpoint_safe_column),
    .restore_checkpoint_success          (restore_checkpoint_success),
    .dispatch_stall                      (dispatch_stall),
    .recover_done                        (recover_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROB contents model, read combinationally at the DUT's walk address.
  logic          rob_dv   [ROB_ENTRIES];
  arch_reg_tag_t rob_arch [ROB_ENTRIES];
  phys_reg_tag_t rob_safe [ROB_ENTRIES];
  phys_reg_tag_t rob_spec [ROB_ENTRIES];

  always_comb begin
    rob_read_dest_valid    = rob_dv[rob_read_index];
    rob_read_arch_tag      = rob_arch[rob_read_index];
    rob_read_safe_phys_tag = rob_safe[rob_read_index];
    rob_read_spec_phys_tag = rob_spec[rob_read_index];
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];
  logic s_rec_ready, s_inv_ready, s_done, s_stall, s_err;
  logic acc_inv_ready;

  function automatic logic [31:0] ev(input logic [3:0] k, input logic sf, input ROB_index_t idx,
                                     input checkpoint_column_t col, input arch_reg_tag_t a,
                                     input phys_reg_tag_t s, input phys_reg_tag_t p);
    return {4'h0, k, sf, idx, col, a, s, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s unexpected event observed=%08h expected=none", tag, obs);
    end
    if (sb.size() != 0) chk(tag, obs, sb.pop_front());
  endtask

  // Sample outputs mid-cycle, match any activity against the scoreboard, advance to next negedge.
  task automatic cycle();
    #2;
    s_rec_ready = recover_req_ready;
    s_inv_ready = invalidate_req_ready;
    s_done      = recover_done;
    s_stall     = dispatch_stall;
    s_err       = DUT_error;
    chk("revert_restore_excl", 32'(revert_valid & restore_checkpoint_valid), 32'd0);
    if (restore_checkpoint_valid)
      sb_check("restore", ev(EV_RST, restore_checkpoint_speculate_failed, restore_checkpoint_ROB_index,
                             restore_checkpoint_safe_column, '0, '0, '0));
    if (dispatch_stall && !restore_checkpoint_valid && !recover_done)
      sb_check("walk_read", ev(EV_READ, 1'b0, rob_read_index, '0, '0, '0, '0));
    if (revert_valid)
      sb_check("revert", ev(EV_REV, 1'b0, '0, '0, revert_dest_arch_reg_tag,
                            revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag));
    if (recover_done)
      sb_check("done", ev(EV_DONE, 1'b0, '0, '0, '0, '0, '0));
    @(negedge CLK);
  endtask

  // Reference model of one recovery: push expected events, run it, check latency and stall.
  task automatic do_recover(input ROB_index_t br, input checkpoint_column_t col,
                            input ROB_index_t tail, input logic succ);
    ROB_index_t w;
    int n, lat, stalls;
    n = 0;
    sb.push_back(ev(EV_RST, 1'b1, br, col, '0, '0, '0));
    w = tail - 4'd1;
    if (!succ && (w != br)) begin
      while (n < 16) begin
        sb.push_back(ev(EV_READ, 1'b0, w, '0, '0, '0, '0));
        if (rob_dv[w]) sb.push_back(ev(EV_REV, 1'b0, '0, '0, rob_arch[w], rob_safe[w], rob_spec[w]));
        n++;
        if (w == br + 4'd1) break;
        w = w - 4'd1;
      end
    end
    sb.push_back(ev(EV_DONE, 1'b0, '0, '0, '0, '0, '0));

    recover_req_valid          = 1'b1;
    recover_req_ROB_index      = br;
    recover_req_column         = col;
    rob_tail_index             = tail;
    restore_checkpoint_success = succ;
    cycle();
    chk("recover_ready_at_accept", 32'(s_rec_ready), 32'd1);
    acc_inv_ready     = s_inv_ready;
    recover_req_valid = 1'b0;
    lat    = 0;
    stalls = 0;
    do begin
      cycle();
      lat++;
      stalls += int'(s_stall);
    end while (!s_done && lat < 40);
    chk("latency", 32'(lat), 32'(2 + n));
    chk("stall_cycles", 32'(stalls), 32'(lat));
  endtask

  initial begin
    nRST                       = 1'b0;
    recover_req_valid          = 1'b0;
    recover_req_ROB_index      = '0;
    recover_req_column         = '0;
    invalidate_req_valid       = 1'b0;
    invalidate_req_ROB_index   = '0;
    invalidate_req_column      = '0;
    rob_tail_index             = '0;
    restore_checkpoint_success = 1'b0;
    for (int i = 0; i < int'(ROB_ENTRIES); i++) begin
      rob_dv[i]   = 1'b0;
      rob_arch[i] = 5'(i + 1);
      rob_safe[i] = 6'(i + 16);
      rob_spec[i] = 6'(i + 40);
    end

    // Reset values
    #2;
    chk("rst_stall", 32'(dispatch_stall), 32'd0);
    chk("rst_recover_ready", 32'(recover_req_ready), 32'd1);
    chk("rst_invalidate_ready", 32'(invalidate_req_ready), 32'd1);
    chk("rst_outputs", 32'({revert_valid, restore_checkpoint_valid, recover_done, DUT_error}), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // T1 checkpoint restore hit
    do_recover(4'd3, 2'd1, 4'd7, 1'b1);
    chk("t1_inv_ready_blocked", 32'(acc_inv_ready), 32'd0);
    cycle();
    chk("t1_idle_stall", 32'(s_stall), 32'd0);

    // T2 walk fallback, entries 6 and 4 renamed a dest
    rob_dv[6] = 1'b1; rob_dv[5] = 1'b0; rob_dv[4] = 1'b1;
    do_recover(4'd3, 2'd2, 4'd7, 1'b0);

    // T3 wrap-around walk
    rob_dv[1] = 1'b1; rob_dv[0] = 1'b0; rob_dv[15] = 1'b1; rob_dv[14] = 1'b1;
    do_recover(4'd14, 2'd3, 4'd2, 1'b0);

    // T4 no younger instructions
    do_recover(4'd5, 2'd0, 4'd6, 1'b0);

    // Longest legal walk (14 entries) must not raise an error
    for (int i = 0; i < int'(ROB_ENTRIES); i++) rob_dv[i] = 1'((i % 3) != 0);
    do_recover(4'd2, 2'd1, 4'd1, 1'b0);
    chk("long_walk_no_error", 32'(s_err), 32'd0);

    // T5 arbitration: invalidate held across a recovery, issued right after done
    invalidate_req_valid     = 1'b1;
    invalidate_req_ROB_index = 4'd9;
    invalidate_req_column    = 2'd2;
    do_recover(4'd8, 2'd3, 4'd10, 1'b1);
    chk("t5_inv_ready_blocked", 32'(acc_inv_ready), 32'd0);
    sb.push_back(ev(EV_RST, 1'b0, 4'd9, 2'd2, '0, '0, '0));
    restore_checkpoint_success = 1'b0;
    cycle();
    chk("t5_inv_ready_after_done", 32'(s_inv_ready), 32'd1);
    invalidate_req_valid = 1'b0;
    cycle();
    chk("t5_inv_fail_stays_idle", 32'(s_stall), 32'd0);
    chk("t5_inv_fail_no_error", 32'(s_err), 32'd0);

    // Branch index equal to tail is a protocol error and is sticky
    do_recover(4'd4, 2'd0, 4'd4, 1'b1);
    cycle();
    chk("err_tail_eq_branch", 32'(s_err), 32'd1);

    // T6 reset mid-walk
    for (int i = 0; i < int'(ROB_ENTRIES); i++) rob_dv[i] = 1'b1;
    sb.push_back(ev(EV_RST, 1'b1, 4'd0, 2'd0, '0, '0, '0));
    for (int i = 7; i >= 6; i--) begin
      sb.push_back(ev(EV_READ, 1'b0, 4'(i), '0, '0, '0, '0));
      sb.push_back(ev(EV_REV, 1'b0, '0, '0, rob_arch[i], rob_safe[i], rob_spec[i]));
    end
    recover_req_valid          = 1'b1;
    recover_req_ROB_index      = 4'd0;
    recover_req_column         = 2'd0;
    rob_tail_index             = 4'd8;
    restore_checkpoint_success = 1'b0;
    cycle();
    recover_req_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    #1;
    chk("t6_pre_reset_revert", 32'(revert_valid), 32'd1);
    chk("t6_pre_reset_read_idx", 32'(rob_read_index), 32'd5);
    nRST = 1'b0;
    #1;
    chk("t6_reset_revert", 32'(revert_valid), 32'd0);
    chk("t6_reset_stall", 32'(dispatch_stall), 32'd0);
    chk("t6_reset_error_clear", 32'(DUT_error), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    cycle();
    chk("t6_release_stall", 32'(s_stall), 32'd0);
    chk("t6_release_ready", 32'(s_rec_ready), 32'd1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
